// File: rtl/quad_pkg.sv
// quad_pkg: shared arbiter state encoding and default bus-error read data.
package quad_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam logic [31:0] BUS_ERR_DEFAULT = 32'hDEAD_BEEF;
    function automatic state_t own_of(input logic m);
        return m ? OWN1 : OWN0;
    endfunction
endpackage

// File: rtl/quad_wb_arbiter_if.sv
// quad_wb_arbiter_if: two serv-style masters, one shared slave and the timeout flag around the arbiter.
interface quad_wb_arbiter_if;
    logic [31:0] i_m0_adr, i_m1_adr, i_m0_dat, i_m1_dat;
    logic [3:0]  i_m0_sel, i_m1_sel;
    logic        i_m0_we, i_m1_we, i_m0_cyc, i_m1_cyc;
    logic [31:0] o_m0_rdt, o_m1_rdt;
    logic        o_m0_ack, o_m1_ack;
    logic [31:0] o_s_adr, o_s_dat;
    logic [3:0]  o_s_sel;
    logic        o_s_we, o_s_cyc;
    logic [31:0] i_s_rdt;
    logic        i_s_ack;
    logic        o_timeout, i_timeout_clr;
    modport master(
        output i_m0_adr, i_m1_adr, i_m0_dat, i_m1_dat, i_m0_sel, i_m1_sel,
               i_m0_we, i_m1_we, i_m0_cyc, i_m1_cyc, i_s_rdt, i_s_ack, i_timeout_clr,
        input  o_m0_rdt, o_m1_rdt, o_m0_ack, o_m1_ack, o_s_adr, o_s_dat, o_s_sel,
               o_s_we, o_s_cyc, o_timeout
    );
    modport slave(
        input  i_m0_adr, i_m1_adr, i_m0_dat, i_m1_dat, i_m0_sel, i_m1_sel,
               i_m0_we, i_m1_we, i_m0_cyc, i_m1_cyc, i_s_rdt, i_s_ack, i_timeout_clr,
        output o_m0_rdt, o_m1_rdt, o_m0_ack, o_m1_ack, o_s_adr, o_s_dat, o_s_sel,
               o_s_we, o_s_cyc, o_timeout
    );
endinterface

// File: rtl/quad_rr_pick.sv
// quad_rr_pick: 2-way round-robin select; on a tie the master that was not granted last wins.
module quad_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic pick
);
    assign valid = req0 | req1;
    assign pick  = (req0 & req1) ? ~last_grant : req1;
endmodule

// File: rtl/quad_wb_arbiter.sv
// quad_wb_arbiter: round-robin arbiter letting two serv-style masters share one wishbone slave,
// with a per-access wait timeout that answers the master with error data.
module quad_wb_arbiter
    import quad_pkg::*;
#(
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] BUS_ERR_DATA = BUS_ERR_DEFAULT
) (
    input logic            i_clk,
    input logic            i_rst_n,
    quad_wb_arbiter_if.slave bus
);
    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);
    state_t        state;
    logic          last_grant, timeout_q, pick_valid, pick;
    logic [CW-1:0] cnt;
    logic          own0, own1, own, cyc_g, fire;
    quad_rr_pick u_pick (
        .req0      (bus.i_m0_cyc),
        .req1      (bus.i_m1_cyc),
        .last_grant(last_grant),
        .valid     (pick_valid),
        .pick      (pick)
    );
    assign own0  = state == OWN0;
    assign own1  = state == OWN1;
    assign own   = own0 | own1;
    assign cyc_g = own1 ? bus.i_m1_cyc : bus.i_m0_cyc;
    // a slave ack in the limit cycle is a normal completion, so the timeout only fires without one
    assign fire  = own & cyc_g & ~bus.i_s_ack & (cnt == TMAX);
    always_comb begin
        bus.o_s_adr   = own1 ? bus.i_m1_adr : bus.i_m0_adr;
        bus.o_s_dat   = own1 ? bus.i_m1_dat : bus.i_m0_dat;
        bus.o_s_sel   = own1 ? bus.i_m1_sel : bus.i_m0_sel;
        bus.o_s_we    = own1 ? bus.i_m1_we : bus.i_m0_we;
        bus.o_s_cyc   = own & cyc_g & ~fire;
        bus.o_m0_ack  = own0 & (bus.i_s_ack | fire);
        bus.o_m1_ack  = own1 & (bus.i_s_ack | fire);
        bus.o_m0_rdt  = own0 ? (fire ? BUS_ERR_DATA : bus.i_s_rdt) : '0;
        bus.o_m1_rdt  = own1 ? (fire ? BUS_ERR_DATA : bus.i_s_rdt) : '0;
        bus.o_timeout = timeout_q;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= fire | (timeout_q & ~bus.i_timeout_clr);
            if (!own) begin
                if (pick_valid) begin
                    state <= own_of(pick);
                    cnt   <= '0;
                end
            end else if (bus.i_s_ack || fire) begin
                state      <= IDLE;
                last_grant <= own1;
            end else if (!cyc_g) begin
                state <= IDLE;
            end else if (cnt != TMAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_quad_wb_arbiter.sv
// tb_quad_wb_arbiter: directed scenarios checked every cycle against an ownership/wait-count model.
module tb_quad_wb_arbiter;
    localparam int TMO = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    quad_wb_arbiter_if bus();
    quad_wb_arbiter #(.TIMEOUT(TMO)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    int checks = 0;
    int passed = 0;
    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    int owner = -1;
    int last = 1;
    int waited = 0;
    bit tflag = 1'b0;
    logic cyc_o, tmo;
    logic [68:0] exp_bus;
    // owner -1 means nobody holds the slave; waited counts unacked owned cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            owner = -1;
            last = 1;
            waited = 0;
            tflag = 1'b0;
        end
        cyc_o = owner == 1 ? bus.i_m1_cyc : owner == 0 ? bus.i_m0_cyc : 1'b0;
        tmo = owner >= 0 && cyc_o && !bus.i_s_ack && waited == TMO;
        exp_bus = owner == 1 ? {bus.i_m1_adr, bus.i_m1_dat, bus.i_m1_sel, bus.i_m1_we}
                             : {bus.i_m0_adr, bus.i_m0_dat, bus.i_m0_sel, bus.i_m0_we};
        check("s_cyc", bus.o_s_cyc, owner >= 0 && cyc_o && !tmo);
        check("s_bus", {bus.o_s_adr, bus.o_s_dat, bus.o_s_sel, bus.o_s_we}, exp_bus);
        check("m0_ack", bus.o_m0_ack, owner == 0 && (bus.i_s_ack || tmo));
        check("m1_ack", bus.o_m1_ack, owner == 1 && (bus.i_s_ack || tmo));
        check("m0_rdt", bus.o_m0_rdt, owner == 0 ? (tmo ? 32'hDEAD_BEEF : bus.i_s_rdt) : 32'h0);
        check("m1_rdt", bus.o_m1_rdt, owner == 1 ? (tmo ? 32'hDEAD_BEEF : bus.i_s_rdt) : 32'h0);
        check("timeout", bus.o_timeout, tflag);
        if (rst_n) begin
            if (owner < 0) begin
                if (bus.i_m0_cyc || bus.i_m1_cyc) begin
                    owner = (bus.i_m0_cyc && bus.i_m1_cyc) ? 1 - last : (bus.i_m1_cyc ? 1 : 0);
                    waited = 0;
                end
            end else if (bus.i_s_ack || tmo) begin
                last = owner;
                owner = -1;
            end else if (!cyc_o) begin
                owner = -1;
            end else if (waited < TMO) begin
                waited++;
            end
            tflag = tmo || (tflag && !bus.i_timeout_clr);
        end
    end
    initial begin
        {bus.i_m0_adr, bus.i_m1_adr, bus.i_m0_dat, bus.i_m1_dat} = '0;
        {bus.i_m0_sel, bus.i_m1_sel, bus.i_m0_we, bus.i_m1_we} = '0;
        {bus.i_m0_cyc, bus.i_m1_cyc, bus.i_s_rdt, bus.i_s_ack, bus.i_timeout_clr} = '0;
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_cyc", bus.o_s_cyc, 0);
        check("rst_timeout", bus.o_timeout, 0);
        check("rst_acks", {bus.o_m0_ack, bus.o_m1_ack}, 0);
        step();
        bus.i_s_ack = 1'b1;
        bus.i_s_rdt = 32'h55;
        @(negedge clk);
        check("idle_ack_ignored", {bus.o_m0_ack, bus.o_m1_ack}, 0);
        check("idle_rdt_zero", bus.o_m0_rdt, 0);
        step();
        bus.i_s_ack = 1'b0;
        bus.i_m0_cyc = 1'b1;
        bus.i_m0_adr = 32'h100;
        bus.i_m0_sel = 4'hF;
        step();
        @(negedge clk);
        check("m0_s_cyc_cycle1", bus.o_s_cyc, 1);
        check("m0_s_adr", bus.o_s_adr, 32'h100);
        step();
        step();
        bus.i_s_ack = 1'b1;
        bus.i_s_rdt = 32'h1234_5678;
        @(negedge clk);
        check("m0_ack_cycle3", bus.o_m0_ack, 1);
        check("m0_rdt_data", bus.o_m0_rdt, 32'h1234_5678);
        check("m1_ack_quiet", bus.o_m1_ack, 0);
        step();
        bus.i_s_ack = 1'b0;
        bus.i_m0_cyc = 1'b0;
        step();
        bus.i_m0_cyc = 1'b1;
        bus.i_m0_we = 1'b1;
        bus.i_m0_adr = 32'h200;
        bus.i_m0_dat = 32'hA5A5_0F0F;
        bus.i_m0_sel = 4'b0011;
        step();
        bus.i_s_ack = 1'b1;
        @(negedge clk);
        check("wr_fields", {bus.o_s_we, bus.o_s_dat, bus.o_s_sel}, {1'b1, 32'hA5A5_0F0F, 4'b0011});
        step();
        bus.i_s_ack = 1'b0;
        bus.i_m0_cyc = 1'b0;
        bus.i_m0_we = 1'b0;
        rst_n = 1'b0;
        bus.i_m0_cyc = 1'b1;
        bus.i_m1_cyc = 1'b1;
        bus.i_m0_adr = 32'h1000;
        bus.i_m1_adr = 32'h2000;
        step();
        rst_n = 1'b1;
        step();
        bus.i_s_ack = 1'b1;
        bus.i_s_rdt = 32'h11;
        @(negedge clk);
        check("tie_first_m0", bus.o_s_adr, 32'h1000);
        check("tie_first_ack0", bus.o_m0_ack, 1);
        step();
        bus.i_s_ack = 1'b0;
        @(negedge clk);
        check("tie_gap_idle", bus.o_s_cyc, 0);
        step();
        bus.i_s_ack = 1'b1;
        bus.i_s_rdt = 32'h22;
        @(negedge clk);
        check("tie_second_m1", bus.o_s_adr, 32'h2000);
        check("tie_second_ack1", bus.o_m1_ack, 1);
        step();
        bus.i_s_ack = 1'b0;
        step();
        bus.i_s_ack = 1'b1;
        @(negedge clk);
        check("tie_repeat_m0", bus.o_s_adr, 32'h1000);
        step();
        bus.i_s_ack = 1'b0;
        bus.i_m0_cyc = 1'b0;
        bus.i_m1_cyc = 1'b0;
        step();
        bus.i_m1_cyc = 1'b1;
        bus.i_m1_adr = 32'h3000;
        for (int i = 0; i < TMO; i++) begin
            step();
            @(negedge clk);
            check("to_wait_no_ack", bus.o_m1_ack, 0);
        end
        step();
        bus.i_timeout_clr = 1'b1;
        @(negedge clk);
        check("to_ack1", bus.o_m1_ack, 1);
        check("to_rdt1", bus.o_m1_rdt, 32'hDEAD_BEEF);
        check("to_s_cyc_low", bus.o_s_cyc, 0);
        step();
        bus.i_timeout_clr = 1'b0;
        bus.i_m1_cyc = 1'b0;
        @(negedge clk);
        check("to_flag_set_wins", bus.o_timeout, 1);
        step();
        step();
        bus.i_timeout_clr = 1'b1;
        @(negedge clk);
        check("to_flag_held", bus.o_timeout, 1);
        step();
        bus.i_timeout_clr = 1'b0;
        @(negedge clk);
        check("to_flag_cleared", bus.o_timeout, 0);
        step();
        bus.i_m0_cyc = 1'b1;
        bus.i_m0_adr = 32'h4000;
        repeat (TMO) step();
        step();
        bus.i_s_ack = 1'b1;
        bus.i_s_rdt = 32'hCAFE_0001;
        @(negedge clk);
        check("race_ack0", bus.o_m0_ack, 1);
        check("race_rdt0", bus.o_m0_rdt, 32'hCAFE_0001);
        check("race_s_cyc", bus.o_s_cyc, 1);
        step();
        bus.i_s_ack = 1'b0;
        bus.i_m0_cyc = 1'b0;
        @(negedge clk);
        check("race_no_flag", bus.o_timeout, 0);
        step();
        bus.i_m0_cyc = 1'b1;
        bus.i_m1_cyc = 1'b1;
        step();
        @(negedge clk);
        check("rst_mid_own1", bus.o_s_adr, 32'h3000);
        step();
        rst_n = 1'b0;
        #1;
        check("rst_drops_s_cyc", bus.o_s_cyc, 0);
        check("rst_no_ack1", bus.o_m1_ack, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_idle", bus.o_s_cyc, 0);
        step();
        @(negedge clk);
        check("rst_tie_m0", bus.o_s_adr, 32'h4000);
        check("rst_tie_s_cyc", bus.o_s_cyc, 1);
        bus.i_s_ack = 1'b1;
        step();
        bus.i_s_ack = 1'b0;
        bus.i_m0_cyc = 1'b0;
        step();
        bus.i_m0_cyc = 1'b1;
        @(negedge clk);
        check("abort_own1", bus.o_s_adr, 32'h3000);
        step();
        bus.i_m1_cyc = 1'b0;
        @(negedge clk);
        check("abort_s_cyc_low", bus.o_s_cyc, 0);
        check("abort_no_ack1", bus.o_m1_ack, 0);
        step();
        @(negedge clk);
        check("abort_idle", bus.o_s_cyc, 0);
        step();
        bus.i_s_ack = 1'b1;
        @(negedge clk);
        check("abort_then_m0", bus.o_s_adr, 32'h4000);
        check("abort_m0_ack", bus.o_m0_ack, 1);
        step();
        bus.i_s_ack = 1'b0;
        bus.i_m0_cyc = 1'b0;
        repeat (3) step();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/quad_wb_arbiter.md
QUAD_WB_ARBITER -- requirements
Module: quad_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of cycles a granted access may wait for slave ack before it is aborted; legal range 1..65535.
REQ-002 SHALL have parameter BUS_ERR_DATA, default 32'hDEAD_BEEF, meaning the read data returned to a master whose access timed out.
REQ-003 SHALL have port i_clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_m0_adr / i_m1_adr  in  32  master 0 (CPU ibus) / master 1 (CPU dbus) address.
REQ-006 SHALL have ports i_m0_dat / i_m1_dat  in  32  master write data.
REQ-007 SHALL have ports i_m0_sel / i_m1_sel  in  4  master byte selects.
REQ-008 SHALL have ports i_m0_we / i_m1_we  in  1  master write enable.
REQ-009 SHALL have ports i_m0_cyc / i_m1_cyc  in  1  master request; held high until ack (serv style, no stb).
REQ-010 SHALL have ports o_m0_rdt / o_m1_rdt  out  32  read data to each master.
REQ-011 SHALL have ports o_m0_ack / o_m1_ack  out  1  single-cycle ack to each master.
REQ-012 SHALL have ports o_s_adr, o_s_dat  out  32 each  address and write data to the shared slave (RAM/ROM).
REQ-013 SHALL have ports o_s_sel  out  4, o_s_we  out  1, o_s_cyc  out  1  slave selects, write enable and cycle.
REQ-014 SHALL have ports i_s_rdt  in  32, i_s_ack  in  1  slave read data and ack.
REQ-015 SHALL have ports o_timeout  out  1 (sticky timeout flag) and i_timeout_clr  in  1 (clears the flag).

Function
REQ-016 SHALL implement a state machine with states IDLE, OWN0, OWN1, plus a last_grant bit.
REQ-017 IDLE with exactly one cyc high SHALL go to that master's OWN state on the next edge.
REQ-018 IDLE with both cyc high SHALL grant the master that is not last_grant (round-robin).
REQ-019 o_s_cyc SHALL be high only in OWNx while i_mx_cyc is high and timeout has not fired, giving 1 cycle of latency from request to slave cyc.
REQ-020 o_s_adr/dat/sel/we SHALL mux combinationally from the granted master; in IDLE they SHALL be driven from master 0 with o_s_cyc low.
REQ-021 o_mx_ack SHALL equal i_s_ack only while OWNx; o_mx_rdt SHALL equal i_s_rdt while OWNx, else 0.
REQ-022 On i_s_ack in OWNx, the FSM SHALL return to IDLE and set last_grant=x; the next grant comes at the earliest 1 cycle later (one IDLE cycle between accesses).
REQ-023 i_s_ack received in IDLE SHALL be ignored, with no master ack.
REQ-024 If i_mx_cyc drops in OWNx without ack (abort), the FSM SHALL return to IDLE without changing last_grant.
REQ-025 The wait counter SHALL be cleared on entry to OWNx and SHALL increment on each OWNx cycle without ack; its width is clog2(TIMEOUT+1) and it SHALL never wrap.
REQ-026 When the counter equals TIMEOUT with no ack, the arbiter SHALL, for that cycle:
- pulse o_mx_ack;
- drive o_mx_rdt=BUS_ERR_DATA;
- force o_s_cyc low;
- set o_timeout;
- go to IDLE with last_grant=x.
REQ-027 A slave ack arriving in the same cycle as the timeout SHALL win: a normal ack with slave data, and o_timeout not set.
REQ-028 i_timeout_clr SHALL clear o_timeout; if a set and a clear occur in the same cycle, the set SHALL win.

Reset
REQ-029 i_rst_n low SHALL immediately force: state=IDLE, last_grant=1 (so master 0 wins the first tie), counter=0, o_timeout=0, all acks=0, o_s_cyc=0.
REQ-030 Reset asserted mid-access SHALL abandon the access; no ack is issued for it after reset release.

Structure
REQ-031 The state encoding and default BUS_ERR_DATA SHALL live in shared package quad_pkg.
REQ-032 The design SHALL use one sub-module, quad_rr_pick (2-way round-robin select from request pair and last_grant).

Verification
REQ-033 m0 cyc only, slave acks 2 cycles after o_s_cyc -> o_s_cyc high in cycle 1 after the request; o_m0_ack in cycle 3 with rdt=slave data; o_m1_ack stays 0.
REQ-034 m0 and m1 cyc both high from reset release -> m0 granted first, then m1 after one IDLE cycle; a repeat tie grants m0 again.
REQ-035 TIMEOUT=4, slave never acks on an m1 read -> o_m1_ack after 4 OWN1 cycles with rdt=32'hDEAD_BEEF; o_timeout=1 until i_timeout_clr.
REQ-036 TIMEOUT=4, slave ack in exactly the timeout cycle -> normal ack with slave data; o_timeout stays 0.
REQ-037 i_rst_n pulsed low during an OWN1 wait -> o_s_cyc drops at once; no ack; m0 wins the next tie.
REQ-038 m1 drops cyc in OWN1 before ack -> FSM returns to IDLE and a pending m0 request is granted next.
